// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller/monitor pair:
// light and fault encodings, monitor state enum and phase helpers.
package tl_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [2:0] FLT_NONE        = 3'd0;
    localparam logic [2:0] FLT_ILLEGAL     = 3'd1;
    localparam logic [2:0] FLT_BAD_SEQ     = 3'd2;
    localparam logic [2:0] FLT_SHORT_DWELL = 3'd3;
    localparam logic [2:0] FLT_STUCK       = 3'd4;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FAULT
    } mon_state_e;

    // Legal successor of a phase; 000 for anything that is not a phase.
    function automatic logic [2:0] next_phase(input logic [2:0] light);
        case (light)
            LIGHT_GREEN:  return LIGHT_YELLOW;
            LIGHT_YELLOW: return LIGHT_RED;
            LIGHT_RED:    return LIGHT_GREEN;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic logic is_phase(input logic [2:0] light);
        return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/tl_flasher.sv
// Square-wave flasher: output starts high after restart and toggles every
// FLASH_DIV cycles. Shared by the monitor fault lamp and night mode.
module tl_flasher #(
    parameter int unsigned FLASH_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic flash_o
);

    localparam int unsigned CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(FLASH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flash_q, flash_d;

    always_comb begin
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (restart_i) begin
            cnt_d   = '0;
            flash_d = 1'b1;
        end else if (cnt_q == TERM) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            flash_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
        end
    end

    assign flash_o = flash_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor between traffic_signal and the lamps; latches the first fault
// and flashes red until cleared. TL_MON_STATS_EN adds the cycles_done counter.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MIN_RED    = 4,
    parameter int unsigned MAX_DWELL  = 32,
    parameter int unsigned FLASH_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  light_in,
    input  logic        clr_fault,
    output logic [2:0]  lamp_out,
    output logic        fault,
`ifdef TL_MON_STATS_EN
    output logic [15:0] cycles_done,
`endif
    output logic [2:0]  fault_code
);

    localparam logic [CNT_W-1:0] MIN_G_W = MIN_GREEN[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MIN_Y_W = MIN_YELLOW[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MIN_R_W = MIN_RED[CNT_W-1:0];
    localparam logic [CNT_W:0]   MAX_W   = MAX_DWELL[CNT_W:0];

    mon_state_e       state_q, state_d;
    logic [2:0]       light_q;
    logic [CNT_W-1:0] dwell_q, dwell_d, dwell_inc;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [2:0]       viol_code;
    logic [CNT_W-1:0] min_dwell;
    logic             changed;
    logic             flash;

    assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
    assign changed   = (light_in != light_q);

    always_comb begin
        min_dwell = '0;
        case (light_q)
            LIGHT_GREEN:  min_dwell = MIN_G_W;
            LIGHT_YELLOW: min_dwell = MIN_Y_W;
            LIGHT_RED:    min_dwell = MIN_R_W;
            default:      min_dwell = '0;
        endcase
    end

    // Checks in priority order; only acted on while in RUN.
    always_comb begin
        viol_code = FLT_NONE;
        if (!is_phase(light_in)) begin
            viol_code = FLT_ILLEGAL;
        end else if (changed && (light_in != next_phase(light_q))) begin
            viol_code = FLT_BAD_SEQ;
        end else if (changed && (dwell_q < min_dwell)) begin
            viol_code = FLT_SHORT_DWELL;
        end else if (!changed && (({1'b0, dwell_q} + 1'b1) >= MAX_W)) begin
            viol_code = FLT_STUCK;
        end
    end

    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_inc;
        fault_code_d = fault_code_q;
        lamp_out     = LIGHT_RED;
        case (state_q)
            ST_INIT: begin
                dwell_d = '0;
                if (is_phase(light_in)) begin
                    state_d = ST_RUN;
                    dwell_d = CNT_W'(1);
                end
            end
            ST_RUN: begin
                lamp_out = light_q;
                if (changed) begin
                    dwell_d = CNT_W'(1);
                end
                if (viol_code != FLT_NONE) begin
                    state_d      = ST_FAULT;
                    fault_code_d = viol_code;
                end
            end
            ST_FAULT: begin
                lamp_out = {flash, 2'b00};
                if (clr_fault) begin
                    state_d      = ST_INIT;
                    dwell_d      = '0;
                    fault_code_d = FLT_NONE;
                end
            end
            default: begin
                state_d = ST_INIT;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            light_q      <= LIGHT_RED;
            dwell_q      <= '0;
            fault_code_q <= FLT_NONE;
        end else begin
            state_q      <= state_d;
            light_q      <= light_in;
            dwell_q      <= dwell_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Held in restart outside FAULT so the first fault cycle always shows red.
    tl_flasher #(
        .FLASH_DIV(FLASH_DIV)
    ) u_flasher (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i((state_q != ST_FAULT) || clr_fault),
        .flash_o  (flash)
    );

    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_code_q;

`ifdef TL_MON_STATS_EN
    logic [15:0] cycles_q;
    logic        cyc_inc;

    assign cyc_inc = (state_q == ST_RUN) && (viol_code == FLT_NONE) &&
                     (light_q == LIGHT_RED) && (light_in == LIGHT_GREEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if ((state_q == ST_FAULT) && clr_fault) begin
            cycles_q <= '0;
        end else if (cyc_inc) begin
            cycles_q <= cycles_q + 16'd1;
        end
    end

    assign cycles_done = cycles_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk;
    logic        rst_n;
    logic [2:0]  light_in;
    logic        clr_fault;
    logic [2:0]  lamp_out;
    logic        fault;
    logic [2:0]  fault_code;
`ifdef TL_MON_STATS_EN
    logic [15:0] cycles_done;
`endif

    int unsigned checks;
    int unsigned errors;

    traffic_light_monitor #(
        .CNT_W     (8),
        .MIN_GREEN (4),
        .MIN_YELLOW(2),
        .MIN_RED   (4),
        .MAX_DWELL (32),
        .FLASH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .light_in   (light_in),
        .clr_fault  (clr_fault),
        .lamp_out   (lamp_out),
        .fault      (fault),
`ifdef TL_MON_STATS_EN
        .cycles_done(cycles_done),
`endif
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one sample, let it be clocked in, observe mid-cycle.
    task automatic apply(input logic [2:0] code);
        light_in = code;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_n(input logic [2:0] code, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) apply(code);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clr_fault = 1'b0;
        apply_n(Y, 3);
        check("rst_lamp", 16'(lamp_out), 16'(R));
        check("rst_fault", 16'(fault), 16'd0);
        check("rst_code", 16'(fault_code), 16'd0);
`ifdef TL_MON_STATS_EN
        check("rst_cycles", cycles_done, 16'd0);
`endif
        rst_n = 1'b1;
    endtask

    logic [2:0] legal_seq [14];
    logic [2:0] exp_lamp;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr_fault = 1'b0;
        light_in  = Y;

        // Reset and entry into RUN on the first legal sample
        do_reset();
        apply(Y);
        check("entry_lamp", 16'(lamp_out), 16'(Y));
        check("entry_fault", 16'(fault), 16'd0);

        // Legal cycle G4 Y2 R4 G4; INIT ignores illegal codes first
        do_reset();
        apply(3'b000);
        apply(3'b111);
        check("init_ignore_lamp", 16'(lamp_out), 16'(R));
        check("init_ignore_fault", 16'(fault), 16'd0);
        legal_seq = '{G, G, G, G, Y, Y, R, R, R, R, G, G, G, G};
        for (int unsigned i = 0; i < 14; i++) begin
            apply(legal_seq[i]);
            check($sformatf("legal_lamp%0d", i), 16'(lamp_out), 16'(legal_seq[i]));
            check($sformatf("legal_fault%0d", i), 16'(fault), 16'd0);
        end
`ifdef TL_MON_STATS_EN
        check("legal_cycles", cycles_done, 16'd1);
`endif
        // clr_fault outside FAULT has no effect
        clr_fault = 1'b1;
        apply(Y);
        clr_fault = 1'b0;
        check("clr_in_run_lamp", 16'(lamp_out), 16'(Y));
`ifdef TL_MON_STATS_EN
        check("clr_in_run_cycles", cycles_done, 16'd1);
`endif

        // Illegal code and flash pattern
        do_reset();
        apply_n(G, 4);
        apply(3'b011);
        check("illegal_fault", 16'(fault), 16'd1);
        check("illegal_code", 16'(fault_code), 16'd1);
        for (int unsigned i = 0; i < 12; i++) begin
            exp_lamp = ((i / 4) % 2 == 0) ? R : 3'b000;
            check($sformatf("flash%0d", i), 16'(lamp_out), 16'(exp_lamp));
            apply(3'b000);
        end
        check("illegal_code_hold", 16'(fault_code), 16'd1);

        // Bad sequence, later violation does not overwrite
        do_reset();
        apply_n(G, 4);
        apply(R);
        check("badseq_fault", 16'(fault), 16'd1);
        check("badseq_code", 16'(fault_code), 16'd2);
        apply(3'b111);
        check("badseq_code_hold", 16'(fault_code), 16'd2);

        // Short dwell on YELLOW
        do_reset();
        apply_n(G, 4);
        apply(Y);
        check("short_pre_fault", 16'(fault), 16'd0);
        apply(R);
        check("short_fault", 16'(fault), 16'd1);
        check("short_code", 16'(fault_code), 16'd3);

        // Stuck boundary, then clear racing a violation input
        do_reset();
        apply_n(G, 31);
        check("stuck_31_fault", 16'(fault), 16'd0);
        check("stuck_31_lamp", 16'(lamp_out), 16'(G));
        apply(G);
        check("stuck_fault", 16'(fault), 16'd1);
        check("stuck_code", 16'(fault_code), 16'd4);
        clr_fault = 1'b1;
        apply(3'b000);
        clr_fault = 1'b0;
        check("clr_lamp", 16'(lamp_out), 16'(R));
        check("clr_fault", 16'(fault), 16'd0);
        check("clr_code", 16'(fault_code), 16'd0);
`ifdef TL_MON_STATS_EN
        check("clr_cycles", cycles_done, 16'd0);
`endif
        apply(G);
        check("rerun_lamp", 16'(lamp_out), 16'(G));

        // Reset overrides clr_fault mid-fault
        apply(R);
        check("refault_code", 16'(fault_code), 16'd2);
        rst_n     = 1'b0;
        clr_fault = 1'b1;
        apply(G);
        check("rst_over_clr_lamp", 16'(lamp_out), 16'(R));
        check("rst_over_clr_code", 16'(fault_code), 16'd0);
        rst_n     = 1'b1;
        clr_fault = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
